// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: pointer width rule, threshold
// legality check and status-register bit positions used by the FIFO wrappers.
package fifo_pkg;

  localparam int STAT_OVF_BIT = 0;
  localparam int STAT_UDF_BIT = 1;
  localparam int STAT_WIDTH   = 2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

  function automatic bit levels_legal(input int addr_bits, input int af_level,
                                      input int ae_level);
    int depth;
    depth = 1 << addr_bits;
    return (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/modn_counter.sv
// Free-running modulo-2^P_NUM_BITS up-counter with enable and a reset sampled
// on the clock edge.
module modn_counter #(
  parameter int P_NUM_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [P_NUM_BITS-1:0] cnt_reg
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer and flag controller for the single-clock FIFO; drives the write and
// read strobes/addresses of an external simple-dual-port RAM.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int P_ADDR_BITS = 4,
  parameter int P_AF_LEVEL  = 12,
  parameter int P_AE_LEVEL  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic                   clr_err,
  output logic                   mem_we,
  output logic [P_ADDR_BITS-1:0] mem_waddr,
  output logic                   mem_re,
  output logic [P_ADDR_BITS-1:0] mem_raddr,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [P_ADDR_BITS:0]   count,
  output logic                   ovf,
  output logic                   udf
);

  localparam int PW = ptr_width(P_ADDR_BITS);
  localparam logic [PW-1:0] AF_LVL = PW'(P_AF_LEVEL);
  localparam logic [PW-1:0] AE_LVL = PW'(P_AE_LEVEL);

  if (!levels_legal(P_ADDR_BITS, P_AF_LEVEL, P_AE_LEVEL)) begin : g_bad_levels
    $fatal(1, "sync_fifo_ctrl: illegal almost_full/almost_empty levels");
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;

  // Strobes are held low through the whole reset cycle, not just after it.
  assign wr_acc = wr_req & ~full & ~rst;
  assign rd_acc = rd_req & ~empty & ~rst;

  modn_counter #(.P_NUM_BITS(PW)) u_wptr (
    .clk     (clk),
    .rst_n   (~rst),
    .en      (wr_acc),
    .cnt_reg (wptr)
  );

  modn_counter #(.P_NUM_BITS(PW)) u_rptr (
    .clk     (clk),
    .rst_n   (~rst),
    .en      (rd_acc),
    .cnt_reg (rptr)
  );

  assign mem_we    = wr_acc;
  assign mem_re    = rd_acc;
  assign mem_waddr = wptr[P_ADDR_BITS-1:0];
  assign mem_raddr = rptr[P_ADDR_BITS-1:0];

  assign empty        = (wptr == rptr);
  assign full         = (wptr[PW-1] != rptr[PW-1]) &&
                        (wptr[PW-2:0] == rptr[PW-2:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // Error set takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_req && full) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
      if (rd_req && empty) begin
        udf <= 1'b1;
      end else if (clr_err) begin
        udf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed scenarios plus random
// push/pop traffic compared against an occupancy/total-count reference model.
module tb_sync_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          clr_err = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;

  sync_fifo_ctrl #(
    .P_ADDR_BITS (AW),
    .P_AF_LEVEL  (AF),
    .P_AE_LEVEL  (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr_err      (clr_err),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_re       (mem_re),
    .mem_raddr    (mem_raddr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: occupancy plus total words ever pushed/popped since reset.
  int m_cnt  = 0;
  int m_wtot = 0;
  int m_rtot = 0;
  bit m_ovf  = 1'b0;
  bit m_udf  = 1'b0;
  bit m_rv   = 1'b0;
  bit m_known = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model at the edge.
  task automatic step(input bit w, input bit r, input bit c, input bit rs);
    bit m_full, m_empty, exp_we, exp_re;
    wr_req  = w;
    rd_req  = r;
    clr_err = c;
    rst     = rs;
    @(negedge clk);
    m_full  = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    exp_we  = !rs && w && !m_full;
    exp_re  = !rs && r && !m_empty;
    if (m_known) begin
      check("mem_we",       int'(mem_we),       int'(exp_we));
      check("mem_re",       int'(mem_re),       int'(exp_re));
      check("mem_waddr",    int'(mem_waddr),    m_wtot % DEPTH);
      check("mem_raddr",    int'(mem_raddr),    m_rtot % DEPTH);
      check("rd_valid",     int'(rd_valid),     int'(m_rv));
      check("full",         int'(full),         int'(m_full));
      check("empty",        int'(empty),        int'(m_empty));
      check("almost_full",  int'(almost_full),  int'(m_cnt >= AF));
      check("almost_empty", int'(almost_empty), int'(m_cnt <= AE));
      check("count",        int'(count),        m_cnt);
      check("ovf",          int'(ovf),          int'(m_ovf));
      check("udf",          int'(udf),          int'(m_udf));
    end
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_wtot = 0; m_rtot = 0;
      m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
      m_known = 1'b1;
    end else begin
      m_ovf  = (w && m_full)  || (m_ovf && !c);
      m_udf  = (r && m_empty) || (m_udf && !c);
      m_rv   = exp_re;
      m_wtot = m_wtot + int'(exp_we);
      m_rtot = m_rtot + int'(exp_re);
      m_cnt  = m_cnt + int'(exp_we) - int'(exp_re);
    end
    #1;
  endtask

  initial begin
    bit w, r, c, rs;
    bit saw_wrap;
    #1;
    // Reset held two cycles with requests active.
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    check("rst_empty", int'(empty), 1);
    check("rst_ae",    int'(almost_empty), 1);
    check("rst_count", int'(count), 0);

    // Fill to full, watching threshold crossings.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 0, 0);
      if (i == 4)  check("ae_at4",  int'(almost_empty), 1);
      if (i == 5)  check("ae_at5",  int'(almost_empty), 0);
      if (i == 11) check("af_at11", int'(almost_full), 0);
      if (i == 12) check("af_at12", int'(almost_full), 1);
    end
    check("fill_full",  int'(full), 1);
    check("fill_count", int'(count), DEPTH);
    step(1, 0, 0, 0);
    check("ovf_set", int'(ovf), 1);
    step(0, 0, 0, 0);
    check("ovf_hold", int'(ovf), 1);

    // Push+pop at full: only the pop goes.
    step(1, 1, 0, 0);
    check("pp_full_count", int'(count), DEPTH - 1);
    check("pp_full_full",  int'(full), 0);
    check("pp_full_rv",    int'(rd_valid), 1);
    step(0, 0, 1, 0);
    check("ovf_clr", int'(ovf), 0);

    // Drain, then push+pop at empty: only the push goes.
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, 0);
    check("drain_empty", int'(empty), 1);
    step(1, 1, 0, 0);
    check("pp_empty_count", int'(count), 1);
    check("pp_empty_empty", int'(empty), 0);
    check("pp_empty_rv",    int'(rd_valid), 0);
    check("pp_empty_udf",   int'(udf), 1);
    step(0, 1, 1, 1);

    // Wrap-around at constant occupancy 3.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    saw_wrap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_waddr == 4'd15) saw_wrap = 1'b1;
      step(1, 1, 0, 0);
    end
    check("wrap_count", int'(count), 3);
    check("wrap_seen",  int'(saw_wrap), 1);

    // Mid-stream reset at count 7 with a pop pending.
    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    check("mid_count7", int'(count), 7);
    step(0, 1, 0, 1);
    check("mid_count", int'(count), 0);
    check("mid_empty", int'(empty), 1);
    check("mid_rv",    int'(rd_valid), 0);
    check("mid_waddr", int'(mem_waddr), 0);
    step(1, 0, 0, 0);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 299) == 0);
      if (i % 600 < 150) w = ($urandom_range(0, 99) < 85);
      else if (i % 600 < 300) r = ($urandom_range(0, 99) < 85);
      step(w, r, c, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
